// File: rtl/cdc_handshake_tx_if.sv
// Bundle of the source-side valid/ready port and the req/ack/data lines
// toward the destination clock domain.
interface cdc_handshake_tx_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 src_valid_i;
  logic [DataWidth-1:0] src_data_i;
  logic                 src_ready_o;
  logic                 req_o;
  logic [DataWidth-1:0] data_o;
  logic                 ack_i;
  logic                 done_o;
  logic                 busy_o;

  modport master (
    output src_valid_i, src_data_i, ack_i,
    input  src_ready_o, req_o, data_o, done_o, busy_o
  );

  modport slave (
    input  src_valid_i, src_data_i, ack_i,
    output src_ready_o, req_o, data_o, done_o, busy_o
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source end of a four-phase req/ack CDC handshake: latches a word, raises req,
// waits for the synchronised ack to rise and fall before taking the next word.
module cdc_handshake_tx #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned SyncStages = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  cdc_handshake_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [SyncStages-1:0]  r_ack_sync;
  logic                   w_ack_s;
  logic                   w_ready;
  logic                   r_req;
  logic                   w_req_next;
  logic                   r_done;
  logic                   w_done_next;
  logic [DataWidth-1:0]   r_data;
  logic [DataWidth-1:0]   w_data_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SyncStages-2:0], bus.ack_i};
    end
  end

  assign w_ack_s = r_ack_sync[SyncStages-1];

  // A stale ack seen in IDLE blocks new transfers until it returns low.
  assign w_ready = (r_state == IDLE) && !w_ack_s;

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ready && bus.src_valid_i) begin
          w_data_next  = bus.src_data_i;
          w_req_next   = 1'b1;
          w_state_next = REQ_HI;
        end
      end
      REQ_HI: begin
        if (w_ack_s) begin
          w_req_next   = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!w_ack_s) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_done  <= w_done_next;
      r_data  <= w_data_next;
    end
  end

  assign bus.src_ready_o = w_ready;
  assign bus.req_o       = r_req;
  assign bus.data_o      = r_data;
  assign bus.done_o      = r_done;
  assign bus.busy_o      = (r_state != IDLE);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: two instances (2 and 3 sync stages),
// a destination model driven by the stimulus tasks and a separate data monitor.
module tb_cdc_handshake_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ack;
  logic        sel;
  logic [31:0] data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_acc = 0;
  int unsigned exp_done = 0;
  int unsigned acc_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned last_wait = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  cdc_handshake_tx_if #(.DataWidth(32)) b2 ();
  cdc_handshake_tx_if #(.DataWidth(32)) b3 ();

  cdc_handshake_tx #(.DataWidth(32), .SyncStages(2)) u_dut2 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b2)
  );

  cdc_handshake_tx #(.DataWidth(32), .SyncStages(3)) u_dut3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b3)
  );

  assign b2.src_valid_i = sel ? 1'b0 : valid;
  assign b2.src_data_i  = data;
  assign b2.ack_i       = sel ? 1'b0 : ack;
  assign b3.src_valid_i = sel ? valid : 1'b0;
  assign b3.src_data_i  = data;
  assign b3.ack_i       = sel ? ack : 1'b0;

  logic        m_ready, m_req, m_done, m_busy;
  logic [31:0] m_data;
  assign m_ready = sel ? b3.src_ready_o : b2.src_ready_o;
  assign m_req   = sel ? b3.req_o       : b2.req_o;
  assign m_done  = sel ? b3.done_o      : b2.done_o;
  assign m_busy  = sel ? b3.busy_o      : b2.busy_o;
  assign m_data  = sel ? b3.data_o      : b2.data_o;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new request must carry the oldest outstanding offered word.
  initial begin
    logic prev_req;
    logic prev_done;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (m_req && !prev_req) begin
        acc_cnt++;
        held = m_data;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_accept: got 0x%0h expected no transfer", m_data);
        end else begin
          check("data_accept", m_data, exp_q.pop_front());
        end
      end else if (m_req && prev_req) begin
        check("data_hold", m_data, held);
      end
      if (m_done) begin
        done_cnt++;
        check("done_one_cycle", prev_done, 1'b0);
      end
      prev_req  = m_req;
      prev_done = m_done;
    end
  end

  // Full four-phase transfer as seen from both source and destination.
  // Leaves valid=1 with the old word; the caller replaces it at once.
  task automatic xfer(input logic [31:0] w, input int unsigned hi_dly,
                      input int unsigned lo_dly, input bit junk);
    int unsigned s;
    int unsigned cnt;
    s = sel ? 3 : 2;
    valid = 1'b1;
    data  = w;
    exp_q.push_back(w);
    exp_acc++;
    cnt = 0;
    @(negedge clk);
    while (!m_ready && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    last_wait = cnt;
    check("accept_ready", m_ready, 1'b1);
    @(posedge clk); #1;
    for (int unsigned i = 0; i < hi_dly; i++) begin
      if (junk) begin
        valid = 1'($urandom_range(0, 1));
        data  = $urandom;
      end
      @(negedge clk);
      check("busy_req_hi", m_busy, 1'b1);
      @(posedge clk); #1;
    end
    ack = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (junk) begin
        valid = 1'($urandom_range(0, 1));
        data  = $urandom;
      end
    end while (m_req && cnt < 20);
    check("ack_to_req_fall", cnt, s + 1);
    check("done_after_ack", m_done, 1'b1);
    exp_done++;
    for (int unsigned i = 0; i < lo_dly; i++) begin
      if (junk) begin
        valid = 1'($urandom_range(0, 1));
        data  = $urandom;
      end
      @(negedge clk);
      check("busy_req_lo", m_busy, 1'b1);
      @(posedge clk); #1;
    end
    ack   = 1'b0;
    valid = 1'b1;
    data  = w;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!m_ready && cnt < 20);
    check("ackfall_to_ready", cnt, s + 1);
    check("busy_idle", m_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned cnt;
    logic [31:0] w;
    sel   = 1'b0;
    rst_n = 1'b0;
    valid = 1'b0;
    ack   = 1'b0;
    data  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req", m_req, 1'b0);
    check("rst_data", m_data, 32'h0);
    check("rst_done", m_done, 1'b0);
    check("rst_busy", m_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", m_ready, 1'b1);
    @(posedge clk); #1;

    // Single transfer, destination acks 3 cycles after req
    xfer(32'hDEADBEEF, 3, 3, 1'b0);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with valid held high
    xfer(32'h1, 1, 1, 1'b0);
    xfer(32'h2, 0, 2, 1'b0);
    check("no_bubble_2", last_wait, 0);
    xfer(32'h3, 2, 0, 1'b0);
    check("no_bubble_3", last_wait, 0);
    valid = 1'b0;
    @(posedge clk); #1;

    // Stale ack across reset release
    rst_n = 1'b0;
    ack   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("stale_first_cycle_ready", m_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    valid = 1'b1;
    data  = 32'hA5A5A5A5;
    repeat (5) begin
      @(negedge clk);
      check("stale_ready_low", m_ready, 1'b0);
      check("stale_no_req", m_req, 1'b0);
      @(posedge clk); #1;
    end
    ack = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!m_ready && cnt < 20);
    check("stale_release_latency", cnt, 2);
    xfer(32'hA5A5A5A5, 1, 1, 1'b0);
    valid = 1'b0;
    @(posedge clk); #1;

    // Reset while in REQ_HI
    valid = 1'b1;
    data  = 32'h12345678;
    exp_q.push_back(32'h12345678);
    exp_acc++;
    cnt = 0;
    @(negedge clk);
    while (!m_ready && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("midrst_req_before", m_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_req", m_req, 1'b0);
    check("midrst_data", m_data, 32'h0);
    check("midrst_busy", m_busy, 1'b0);
    check("midrst_ready", m_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_done", m_done, 1'b0);
    end
    @(posedge clk); #1;

    // Random transfers with junk on the source port outside IDLE
    for (int unsigned k = 0; k < 12; k++) begin
      w = $urandom;
      xfer(w, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Three-stage synchroniser instance
    sel = 1'b1;
    @(posedge clk); #1;
    xfer(32'hDEADBEEF, 3, 3, 1'b0);
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("accept_count", acc_cnt, exp_acc);
    check("done_count", done_cnt, exp_done);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
